// File: rtl/mem_port_arbiter_if.sv
// Bundles the icache, dcache and main-memory block interfaces that meet at mem_port_arbiter.
// The master modport is the arbiter's view. The slave modport is the view of the caches and the memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 128
);
   logic              i_read;
   logic [ADDR_W-1:0] i_address;
   logic [DATA_W-1:0] i_readdata;
   logic              i_busywait;

   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_address;
   logic [DATA_W-1:0] d_writedata;
   logic [DATA_W-1:0] d_readdata;
   logic              d_busywait;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_writedata;
   logic [DATA_W-1:0] mem_readdata;
   logic              mem_busywait;

   modport master (
      input  i_read, i_address, d_read, d_write, d_address, d_writedata,
             mem_readdata, mem_busywait,
      output i_readdata, i_busywait, d_readdata, d_busywait,
             mem_read, mem_write, mem_address, mem_writedata
   );

   modport slave (
      output i_read, i_address, d_read, d_write, d_address, d_writedata,
             mem_readdata, mem_busywait,
      input  i_readdata, i_busywait, d_readdata, d_busywait,
             mem_read, mem_write, mem_address, mem_writedata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one block-wide memory port between icache and dcache, one transaction at a time.
// Latency is IDLE->WAIT->DONE plus memory time. Callers stall on busywait until their DONE cycle.
module mem_port_arbiter #(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 128,
   parameter int TIMEOUT = 255
) (
   input  logic                clock,
   input  logic                reset,
   mem_port_arbiter_if.master  bus,
   output logic                err
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic G_I = 1'b0;
   localparam logic G_D = 1'b1;

   logic [1:0]       state;
   logic             grant;
   logic             last_grant;
   logic             seen_busy;
   logic [CNT_W-1:0] wait_cnt;

   logic i_req;
   logic d_req;
   logic winner;
   logic complete;
   logic timed_out;

   assign i_req     = bus.i_read;
   assign d_req     = bus.d_read | bus.d_write;
   // A tie goes to whoever was not served last. A lone requester always wins.
   assign winner    = (i_req & d_req) ? ~last_grant : d_req;
   assign complete  = seen_busy & ~bus.mem_busywait;
   assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));

   assign bus.i_busywait = i_req & ~((state == S_DONE) & (grant == G_I));
   assign bus.d_busywait = d_req & ~((state == S_DONE) & (grant == G_D));

   always_ff @(posedge clock) begin
      if (!reset) begin
         state             <= S_IDLE;
         grant             <= G_I;
         last_grant        <= G_I;
         seen_busy         <= 1'b0;
         wait_cnt          <= '0;
         err               <= 1'b0;
         bus.mem_read      <= 1'b0;
         bus.mem_write     <= 1'b0;
         bus.mem_address   <= '0;
         bus.mem_writedata <= '0;
         bus.i_readdata    <= '0;
         bus.d_readdata    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_req | d_req) begin
                  grant           <= winner;
                  bus.mem_address <= winner ? bus.d_address : bus.i_address;
                  // When read and write are both high, the dcache request is a write-back.
                  bus.mem_write     <= winner & bus.d_write;
                  bus.mem_read      <= ~winner | ~bus.d_write;
                  bus.mem_writedata <= (winner & bus.d_write) ? bus.d_writedata : '0;
                  seen_busy         <= 1'b0;
                  wait_cnt          <= '0;
                  state             <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.mem_busywait) begin
                  seen_busy <= 1'b1;
               end
               if (complete) begin
                  if (bus.mem_read) begin
                     if (grant == G_D) begin
                        bus.d_readdata <= bus.mem_readdata;
                     end else begin
                        bus.i_readdata <= bus.mem_readdata;
                     end
                  end
                  bus.mem_read  <= 1'b0;
                  bus.mem_write <= 1'b0;
                  seen_busy     <= 1'b0;
                  last_grant    <= grant;
                  state         <= S_DONE;
               end else if (timed_out) begin
                  bus.mem_read  <= 1'b0;
                  bus.mem_write <= 1'b0;
                  seen_busy     <= 1'b0;
                  err           <= 1'b1;
                  state         <= S_DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_DONE: begin
               wait_cnt <= '0;
               state    <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter. It uses a behavioural memory, a round-robin reference and randomised cache traffic.
module tb_mem_port_arbiter;
   localparam int AW  = 6;
   localparam int DW  = 128;
   localparam int TMO = 255;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic err;
   always #5 clock = ~clock;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus),
      .err  (err)
   );

   logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
   logic [AW-1:0] i_address = '0, d_address = '0;
   logic [DW-1:0] d_writedata = '0;
   bit            mb = 1'b0;
   logic [DW-1:0] mrd = '0;
   assign bus.i_read       = i_read;
   assign bus.i_address    = i_address;
   assign bus.d_read       = d_read;
   assign bus.d_write      = d_write;
   assign bus.d_address    = d_address;
   assign bus.d_writedata  = d_writedata;
   assign bus.mem_busywait = mb;
   assign bus.mem_readdata = mrd;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] data;
      logic          tmo;
   } exp_t;
   exp_t iq[$];
   exp_t dq[$];
   logic grant_log[$];

   logic [DW-1:0] ref_mem[64];
   logic [DW-1:0] mem_store[64];
   logic [DW-1:0] i_last = '0, d_last = '0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic hang(input string name);
      failures++;
      $display("FAIL %s actual=timeout required=response", name);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "bench aborted");
   endtask

   // Memory: each new strobe is busy for fixed_lat cycles (random when fixed_lat is 0). In stuck mode it never finishes.
   bit stuck = 1'b0;
   int fixed_lat = 0;
   bit active = 1'b0;
   int mcnt = 0;
   always @(negedge clock) begin
      if (stuck) begin
         mb = 1'b1;
      end else if (!(bus.mem_read || bus.mem_write)) begin
         active = 1'b0;
         mb = 1'b0;
      end else if (!active) begin
         active = 1'b1;
         mb = 1'b1;
         mcnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 5));
      end else if (mb) begin
         mcnt--;
         if (mcnt == 0) begin
            mb = 1'b0;
            if (bus.mem_read) mrd = mem_store[bus.mem_address];
            else mem_store[bus.mem_address] = bus.mem_writedata;
         end
      end
   end

   // Monitor: it checks each new grant against the round-robin rule and each DONE cycle against the scoreboard.
   logic          p_i = 0, p_d = 0, p_dw = 0, p_strobe = 0, last_win = 0;
   logic [AW-1:0] p_ia = '0, p_da = '0;
   logic [DW-1:0] p_dwd = '0;
   always @(negedge clock) begin
      logic strobe, w;
      exp_t e;
      strobe = bus.mem_read | bus.mem_write;
      if (!reset) begin
         last_win = 1'b0;
      end else begin
         if (strobe && !p_strobe) begin
            if (!p_i && !p_d) begin
               chk("grant_without_request", strobe, 0);
            end else begin
               w = (p_i && p_d) ? ~last_win : p_d;
               chk("grant_addr", bus.mem_address, w ? p_da : p_ia);
               chk("grant_rd", bus.mem_read, w ? !p_dw : 1'b1);
               chk("grant_wr", bus.mem_write, w & p_dw);
               if (w && p_dw) chk("grant_wdata", bus.mem_writedata, p_dwd);
            end
         end
         if (i_read && !bus.i_busywait) begin
            grant_log.push_back(1'b0);
            if (iq.size() == 0) chk("i_spurious_done", 1, 0);
            else begin
               e = iq.pop_front();
               chk("i_readdata", bus.i_readdata, e.data);
               if (e.tmo) chk("tmo_err", err, 1);
               else last_win = 1'b0;
            end
         end
         if ((d_read || d_write) && !bus.d_busywait) begin
            grant_log.push_back(1'b1);
            if (dq.size() == 0) chk("d_spurious_done", 1, 0);
            else begin
               e = dq.pop_front();
               chk("d_readdata", bus.d_readdata, e.data);
               if (e.tmo) chk("tmo_err", err, 1);
               else last_win = 1'b1;
            end
         end
      end
      p_i = i_read; p_d = d_read | d_write; p_dw = d_write;
      p_ia = i_address; p_da = d_address; p_dwd = d_writedata;
      p_strobe = strobe;
   end

   task automatic wait_done(input bit port);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while ((port ? bus.d_busywait : bus.i_busywait) && n < 1000);
      if (port ? bus.d_busywait : bus.i_busywait) hang(port ? "d_done_wait" : "i_done_wait");
   endtask

   task automatic wait_strobe();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!(bus.mem_read || bus.mem_write) && n < 100);
      if (!(bus.mem_read || bus.mem_write)) hang("strobe_wait");
   endtask

   task automatic do_i(input logic [AW-1:0] a, input bit tmo);
      exp_t e;
      @(posedge clock); #2;
      i_read = 1'b1;
      i_address = a;
      e.data = tmo ? i_last : ref_mem[a];
      e.tmo = tmo;
      if (!tmo) i_last = ref_mem[a];
      iq.push_back(e);
      #1 chk("i_busy_immediate", bus.i_busywait, 1);
      wait_done(1'b0);
   endtask

   task automatic do_d(input logic [AW-1:0] a, input bit rd, input bit wr, input logic [DW-1:0] wd);
      exp_t e;
      @(posedge clock); #2;
      d_read = rd;
      d_write = wr;
      d_address = a;
      d_writedata = wd;
      e.tmo = 1'b0;
      if (wr) begin
         ref_mem[a] = wd;
         e.data = d_last;
      end else begin
         e.data = ref_mem[a];
         d_last = ref_mem[a];
      end
      dq.push_back(e);
      #1 chk("d_busy_immediate", bus.d_busywait, 1);
      wait_done(1'b1);
   endtask

   task automatic drop_i();
      @(posedge clock); #2 i_read = 1'b0;
   endtask

   task automatic drop_d();
      @(posedge clock); #2;
      d_read = 1'b0;
      d_write = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clock); #2 reset = 1'b0;
      @(posedge clock); #1;
      chk("rst_mem", {bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_writedata}, 0);
      chk("rst_rdata", {bus.i_readdata, bus.d_readdata}, 0);
      chk("rst_err", err, 0);
      i_last = '0;
      d_last = '0;
      reset = 1'b1;
   endtask

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      int sz, t0;
      logic [DW-1:0] blk_a, wd5;
      for (int a = 0; a < 64; a++) begin
         ref_mem[a] = {4{32'hC0DE_0000 + 32'(a)}};
         mem_store[a] = ref_mem[a];
      end
      blk_a = {32{4'hA}};
      ref_mem[6'h12] = blk_a;
      mem_store[6'h12] = blk_a;

      do_reset();
      chk("rst_busywait", {bus.i_busywait, bus.d_busywait}, 0);

      // A single icache refill with a five-cycle memory access. busywait must rise again after DONE.
      fixed_lat = 5;
      do_i(6'h12, 1'b0);
      @(posedge clock); #2;
      chk("t1_busy_after_done", bus.i_busywait, 1);
      chk("t1_rdata", bus.i_readdata, blk_a);
      i_read = 1'b0;
      fixed_lat = 0;

      // Held dual requests alternate D,I,D,I starting with D after reset.
      do_reset();
      sz = grant_log.size();
      fork
         begin do_i(6'h01, 1'b0); do_i(6'h02, 1'b0); drop_i(); end
         begin do_d(6'h11, 1'b1, 1'b0, rnd128()); do_d(6'h22, 1'b1, 1'b0, rnd128()); drop_d(); end
      join
      if (grant_log.size() >= sz + 4)
         chk("t2_order", {grant_log[sz], grant_log[sz+1], grant_log[sz+2], grant_log[sz+3]}, 4'b1010);
      else
         chk("t2_grant_count", grant_log.size() - sz, 4);

      // A write-back leaves d_readdata alone, and the data reaches the memory.
      wd5 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
      do_d(6'h05, 1'b0, 1'b1, wd5);
      drop_d();
      chk("t3_mem_written", mem_store[6'h05], wd5);

      // Reset in the middle of WAIT drops the transaction. The request is still held, so it completes afterwards.
      fixed_lat = 4;
      @(posedge clock); #2;
      i_read = 1'b1;
      i_address = 6'h0A;
      begin
         exp_t e;
         e.data = ref_mem[6'h0A];
         e.tmo = 1'b0;
         iq.push_back(e);
      end
      wait_strobe();
      @(posedge clock); #2 reset = 1'b0;
      @(posedge clock); #1;
      chk("t4_rst_mem", {bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_writedata}, 0);
      chk("t4_rst_rdata", {bus.i_readdata, bus.d_readdata}, 0);
      chk("t4_busy_held", bus.i_busywait, 1);
      i_last = ref_mem[6'h0A];
      d_last = '0;
      reset = 1'b1;
      wait_done(1'b0);
      drop_i();
      fixed_lat = 0;

      // When the memory never finishes, the transaction aborts after TIMEOUT cycles and err stays set.
      stuck = 1'b1;
      t0 = cyc;
      do_i(6'h03, 1'b1);
      checks++;
      if ((cyc - t0) < TMO || (cyc - t0) > TMO + 4) begin
         failures++;
         $display("FAIL t5_timeout_cycles actual=%0d required=%0d..%0d", cyc - t0, TMO, TMO + 4);
      end
      chk("t5_strobes_dropped", {bus.mem_read, bus.mem_write}, 0);
      stuck = 1'b0;
      drop_i();
      do_d(6'h04, 1'b1, 1'b0, rnd128());
      drop_d();
      chk("t5_err_sticky", err, 1);

      // Read and write both high count as a write. An icache request raised during that write is served next.
      sz = grant_log.size();
      fork
         begin do_d(6'h33, 1'b1, 1'b1, rnd128()); drop_d(); end
         begin wait_strobe(); do_i(6'h21, 1'b0); drop_i(); end
      join
      if (grant_log.size() >= sz + 2)
         chk("t6_order", {grant_log[sz], grant_log[sz+1]}, 2'b10);
      else
         chk("t6_grant_count", grant_log.size() - sz, 2);

      // Random concurrent traffic. Icache reads hit only the lower half and dcache writes hit only the upper half.
      fork
         begin
            for (int k = 0; k < 30; k++) begin
               int gap;
               do_i(AW'($urandom_range(0, 31)), 1'b0);
               gap = $urandom_range(0, 3);
               if (gap > 0) begin
                  drop_i();
                  repeat (gap - 1) @(posedge clock);
               end
            end
            drop_i();
         end
         begin
            for (int k = 0; k < 30; k++) begin
               int op, gap;
               op = $urandom_range(0, 3);
               if (op < 2) do_d(AW'($urandom_range(0, 63)), 1'b1, 1'b0, rnd128());
               else do_d(AW'($urandom_range(32, 63)), op == 3, 1'b1, rnd128());
               gap = $urandom_range(0, 3);
               if (gap > 0) begin
                  drop_d();
                  repeat (gap - 1) @(posedge clock);
               end
            end
            drop_d();
         end
      join

      repeat (5) @(posedge clock);
      #1;
      chk("iq_drained", iq.size(), 0);
      chk("dq_drained", dq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
